// File: rtl/mul_pkg.sv
// Shared multiplier definitions: default widths, product type and latency helper.
package mul_pkg;

    localparam int unsigned MUL_W  = 4;
    localparam int unsigned PROD_W = 2 * MUL_W;

    typedef logic [PROD_W-1:0] prod_t;

    // Multiplier latency for a given pipelining option and multiplier style.
    function automatic int unsigned mul_latency(input int unsigned pipe, input int unsigned m);
        return ((m > 0) ? 1 : 0) + 2 * pipe + ((m > 1) ? 1 : 0);
    endfunction

endpackage

// File: rtl/mul_issue_ctrl_sync_fifo.sv
// Synchronous circular FIFO with storage cleared on reset.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and count; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Credit-based issue front-end for a fixed-latency multiplier with an output FIFO.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned W     = MUL_W,
    parameter int unsigned LAT   = mul_latency(0, 1),
    parameter int unsigned DEPTH = 4,
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic [2*W-1:0]   mul_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_product,
    output logic [OCC_W-1:0] occupancy
);

    localparam int unsigned SR_W = LAT + 1;

    logic [SR_W-1:0]  vld_sr;
    logic             accept;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OCC_W-1:0] fifo_count;
    logic [OCC_W-1:0] inflight;

    assign accept    = in_valid && in_ready;
    assign fifo_pop  = out_valid && out_ready;
    assign inflight  = OCC_W'($countones(vld_sr));
    assign occupancy = inflight + fifo_count;
    // A full FIFO already exhausts the credit; the explicit term keeps overflow impossible by construction.
    assign in_ready  = rst && !fifo_full && (occupancy < OCC_W'(DEPTH));
    assign out_valid = !fifo_empty;

    // Operand registers hold their value across bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (accept) begin
            mul_a <= in_a;
            mul_b <= in_b;
        end
    end

    // Valid tracking through the multiplier pipeline; the top bit marks a product to capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_sr <= '0;
        end else begin
            vld_sr <= SR_W'({vld_sr, accept});
        end
    end

    sync_fifo #(
        .WIDTH (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (vld_sr[LAT]),
        .wdata (mul_product),
        .pop   (fifo_pop),
        .rdata (out_product),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Randomised and directed bench for mul_issue_ctrl across LAT=1/0/3 builds.
module tb_mul_issue_ctrl;

    typedef struct {
        logic [7:0] p;
        int         we;
    } ent_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       out_ready;

    int passed = 0;
    int total  = 0;
    logic [7:0] pop_log [$];

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[inst %0d] @%0t: got %0d, expected %0d", name, g, $time, act, exp);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int unsigned L  = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        localparam int unsigned D  = (g == 0) ? 4 : (g == 1) ? 3 : 6;
        localparam int unsigned OW = $clog2(D + 1);

        logic          inr;
        logic          ovl;
        logic [3:0]    mua;
        logic [3:0]    mub;
        logic [7:0]    prod;
        logic [7:0]    outp;
        logic [OW-1:0] occw;
        logic [7:0]    pipe [4];

        mul_issue_ctrl #(.W(4), .LAT(L), .DEPTH(D)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (in_valid),
            .in_ready    (inr),
            .in_a        (in_a),
            .in_b        (in_b),
            .mul_a       (mua),
            .mul_b       (mub),
            .mul_product (prod),
            .out_valid   (ovl),
            .out_ready   (out_ready),
            .out_product (outp),
            .occupancy   (occw)
        );

        // Stand-in multiplier with L cycles of latency, never stalls.
        always @(posedge clk) begin
            pipe[0] <= 8'(mua) * 8'(mub);
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        if (L == 0) begin : g_comb
            assign prod = 8'(mua) * 8'(mub);
        end else begin : g_pipe
            assign prod = pipe[L-1];
        end

        // Reference: ordered list of accepted-but-not-popped products with their visibility edge.
        ent_t       q [$];
        int         ecnt = 0;
        logic [3:0] ma_m = 0;
        logic [3:0] mb_m = 0;

        always @(negedge clk) begin
            bit mov;
            int sz;
            mov = 0;
            sz  = q.size();
            if (!rst) begin
                chk("rst_in_ready", g, 32'(inr), 0);
                chk("rst_out_valid", g, 32'(ovl), 0);
                chk("rst_out_product", g, 32'(outp), 0);
                chk("rst_occupancy", g, 32'(occw), 0);
                chk("rst_mul_ab", g, {24'(0), mua, mub}, 0);
            end else begin
                mov = (sz > 0) && (q[0].we <= ecnt);
                chk("in_ready", g, 32'(inr), 32'(sz < int'(D)));
                chk("occupancy", g, 32'(occw), 32'(sz));
                chk("out_valid", g, 32'(ovl), 32'(mov));
                if (mov) chk("out_product", g, 32'(outp), 32'(q[0].p));
                chk("mul_ab", g, {24'(0), mua, mub}, {24'(0), ma_m, mb_m});
                chk("no_overflow", g,
                    32'(u_dut.u_fifo.push && u_dut.u_fifo.full && !u_dut.u_fifo.pop), 0);
            end
            // Advance the reference over the coming edge.
            ecnt++;
            if (!rst) begin
                q.delete();
                ma_m = 0;
                mb_m = 0;
            end else begin
                if (mov && out_ready) void'(q.pop_front());
                if (in_valid && sz < int'(D)) begin
                    q.push_back('{p: 8'(in_a) * 8'(in_b), we: ecnt + int'(L) + 1});
                    ma_m = in_a;
                    mb_m = in_b;
                end
            end
        end
    end

    // Products leaving the LAT=1 instance, in pop order.
    always @(negedge clk) begin
        if (rst && gi[0].ovl && out_ready) pop_log.push_back(gi[0].outp);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) tick();
        chk("reset_in_ready", 0, 32'(gi[0].inr), 0);
        chk("reset_occ", 0, 32'(gi[0].occw), 0);
        rst = 1'b1;
        #1;
        chk("ready_after_release", 0, 32'(gi[0].inr), 1);
        tick();

        // Single pair 7*9 on the LAT=1 build.
        in_valid = 1'b1; in_a = 4'd7; in_b = 4'd9;
        tick();
        in_valid = 1'b0;
        chk("sp_mul_a", 0, 32'(gi[0].mua), 7);
        chk("sp_occ_k", 0, 32'(gi[0].occw), 1);
        chk("sp_ov_k", 0, 32'(gi[0].ovl), 0);
        tick();
        chk("sp_ov_k1", 0, 32'(gi[0].ovl), 0);
        tick();
        chk("sp_ov_k2", 0, 32'(gi[0].ovl), 1);
        chk("sp_prod_k2", 0, 32'(gi[0].outp), 63);
        out_ready = 1'b1;
        tick();
        chk("sp_occ_after_pop", 0, 32'(gi[0].occw), 0);
        repeat (5) tick();

        // 15*15 on LAT=0 and LAT=3 builds.
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 4'd15; in_b = 4'd15;
        tick();
        in_valid = 1'b0;
        chk("l0_ov_k", 1, 32'(gi[1].ovl), 0);
        tick();
        chk("l0_ov_k1", 1, 32'(gi[1].ovl), 1);
        chk("l0_prod_k1", 1, 32'(gi[1].outp), 225);
        tick();
        tick();
        chk("l3_ov_k3", 2, 32'(gi[2].ovl), 0);
        tick();
        chk("l3_ov_k4", 2, 32'(gi[2].ovl), 1);
        chk("l3_prod_k4", 2, 32'(gi[2].outp), 225);
        out_ready = 1'b1;
        repeat (4) tick();

        // Streaming 16 back-to-back pairs.
        pop_log.delete();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_a = 4'(i); in_b = 4'(15 - i);
            chk("stream_ready", 0, 32'(gi[0].inr), 1);
            tick();
        end
        in_valid = 1'b0;
        repeat (8) tick();
        chk("stream_count", 0, 32'(pop_log.size()), 16);
        for (int i = 0; i < 16 && i < pop_log.size(); i++)
            chk("stream_prod", 0, 32'(pop_log[i]), 32'(i * (15 - i)));

        // Back-pressure from empty.
        out_ready = 1'b0; in_valid = 1'b1; acc = 0;
        repeat (8) begin
            in_a = 4'($urandom); in_b = 4'($urandom);
            if (gi[0].inr) acc++;
            tick();
        end
        chk("bp_accepted", 0, 32'(acc), 4);
        chk("bp_in_ready", 0, 32'(gi[0].inr), 0);
        chk("bp_occ", 0, 32'(gi[0].occw), 4);
        out_ready = 1'b1;
        repeat (10) begin
            in_a = 4'($urandom); in_b = 4'($urandom);
            tick();
        end
        in_valid = 1'b0;
        repeat (8) tick();

        // Push and pop in the same cycle with three results queued.
        out_ready = 1'b0; in_valid = 1'b1;
        in_a = 4'd1; in_b = 4'd2; tick();
        in_a = 4'd3; in_b = 4'd4; tick();
        in_a = 4'd5; in_b = 4'd6; tick();
        in_valid = 1'b0;
        repeat (2) tick();
        in_valid = 1'b1; in_a = 4'd7; in_b = 4'd8;
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pp_occ", 0, 32'(gi[0].occw), 3);
        chk("pp_head", 0, 32'(gi[0].outp), 12);
        out_ready = 1'b1;
        repeat (8) tick();

        // Reset with work in flight and queued.
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (3) begin
            in_a = 4'($urandom); in_b = 4'($urandom);
            tick();
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("mr_ov", 0, 32'(gi[0].ovl), 0);
        chk("mr_occ", 0, 32'(gi[0].occw), 0);
        chk("mr_in_ready", 0, 32'(gi[0].inr), 0);
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            tick();
            chk("mr_no_stale", 0, 32'(gi[0].ovl), 0);
        end
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 4'd2; in_b = 4'd3;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        chk("mr_after_ov", 0, 32'(gi[0].ovl), 1);
        chk("mr_after_prod", 0, 32'(gi[0].outp), 6);
        out_ready = 1'b1;
        repeat (6) tick();

        // Random traffic with varying back-pressure and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            int ph;
            ph = (i / 200) % 3;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (ph == 0) ? 1'b1 : (ph == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            in_a = 4'($urandom);
            in_b = 4'($urandom);
            rst  = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
